wb_regfile_rns: RTL and testbench

- Write-back consumer for the memory/write-back stage: dual-bank register file holding a binary bank (8-bit) and an RNS bank (NUM_DOMAINS x 8-bit residues).
- Accepts the stage's reg_wr_en / destination_RNS / wr_data write port.
- Serves two registered read ports to decode.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards until the write-back lands.

---
 rtl/rns_pkg.sv | 21 ++
 rtl/wb_bank.sv | 50 +++++
 rtl/wb_regfile_rns.sv | 139 +++++++++++++
 tb/tb_wb_regfile_rns.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants and helpers for the dual-bank (binary + RNS) write-back register file.
package rns_pkg;

    localparam int DOMAIN_WID       = 8;
    localparam int DEF_NUM_DOMAINS  = 1;
    localparam int DEF_REG_ADDR_WID = 4;
    localparam int MAX_DOMAINS      = 16;
    localparam int MAX_DATA_WID     = MAX_DOMAINS * DOMAIN_WID;

    localparam logic BANK_BIN = 1'b0;
    localparam logic BANK_RNS = 1'b1;

    // Zero-extends a binary byte to the widest supported data word; callers cast down to their width.
    function automatic logic [MAX_DATA_WID-1:0] pack_bin(input logic [DOMAIN_WID-1:0] value);
        logic [MAX_DATA_WID-1:0] ext;
        ext                 = {MAX_DATA_WID{1'b0}};
        ext[DOMAIN_WID-1:0] = value;
        return ext;
    endfunction

endpackage

// File: rtl/wb_bank.sv
// One register bank: single write port, two registered write-first read ports, synchronous reset.
module wb_bank
    import rns_pkg::*;
#(
    parameter int DATA_WID = 8,
    parameter int ADDR_WID = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_WID-1:0] wr_addr,
    input  logic [DATA_WID-1:0] wr_data,
    input  logic [ADDR_WID-1:0] rd_addr_a,
    input  logic [ADDR_WID-1:0] rd_addr_b,
    output logic [DATA_WID-1:0] rd_data_a,
    output logic [DATA_WID-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** ADDR_WID;

    logic [DATA_WID-1:0] mem_r [DEPTH];
    logic [DATA_WID-1:0] rd_data_a_r;
    logic [DATA_WID-1:0] rd_data_b_r;

    // Storage array: cleared on reset, written on strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WID{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read registers with write-first bypass so a same-cycle write is visible immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_a_r <= {DATA_WID{1'b0}};
            rd_data_b_r <= {DATA_WID{1'b0}};
        end else begin
            rd_data_a_r <= (wr_en && (wr_addr == rd_addr_a)) ? wr_data : mem_r[rd_addr_a];
            rd_data_b_r <= (wr_en && (wr_addr == rd_addr_b)) ? wr_data : mem_r[rd_addr_b];
        end
    end

    assign rd_data_a = rd_data_a_r;
    assign rd_data_b = rd_data_b_r;

endmodule

// File: rtl/wb_regfile_rns.sv
// Write-back register file with binary and RNS banks, two read ports and a RAW pending-write scoreboard.
module wb_regfile_rns
    import rns_pkg::*;
#(
    parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
    parameter int REG_ADDR_WID = DEF_REG_ADDR_WID
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reg_wr_en,
    input  logic                          destination_RNS,
    input  logic [REG_ADDR_WID-1:0]       wr_addr,
    input  logic [NUM_DOMAINS*8-1:0]      wr_data,
    input  logic [REG_ADDR_WID-1:0]       rd_addr_a,
    input  logic [REG_ADDR_WID-1:0]       rd_addr_b,
    input  logic                          rd_rns_a,
    input  logic                          rd_rns_b,
    output logic [NUM_DOMAINS*8-1:0]      rd_data_a,
    output logic [NUM_DOMAINS*8-1:0]      rd_data_b,
    input  logic                          issue_en,
    input  logic [REG_ADDR_WID-1:0]       issue_addr,
    input  logic                          issue_rns,
    input  logic                          flush,
    output logic                          hazard_a,
    output logic                          hazard_b
);

    localparam int DATA_WID = NUM_DOMAINS * DOMAIN_WID;
    localparam int DEPTH    = 2 ** REG_ADDR_WID;

    logic                  bin_wr_en_s;
    logic                  rns_wr_en_s;
    logic [DOMAIN_WID-1:0] bin_rd_a_s;
    logic [DOMAIN_WID-1:0] bin_rd_b_s;
    logic [DATA_WID-1:0]   rns_rd_a_s;
    logic [DATA_WID-1:0]   rns_rd_b_s;
    logic                  rd_rns_a_r;
    logic                  rd_rns_b_r;
    logic [DEPTH-1:0]      pend_bin_r;
    logic [DEPTH-1:0]      pend_rns_r;
    logic [DEPTH-1:0]      pend_bin_s;
    logic [DEPTH-1:0]      pend_rns_s;

    assign bin_wr_en_s = reg_wr_en && (destination_RNS == BANK_BIN);
    assign rns_wr_en_s = reg_wr_en && (destination_RNS == BANK_RNS);

    wb_bank #(.DATA_WID(DOMAIN_WID), .ADDR_WID(REG_ADDR_WID)) u_bin_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (bin_wr_en_s),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data[DOMAIN_WID-1:0]),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (bin_rd_a_s),
        .rd_data_b (bin_rd_b_s)
    );

    wb_bank #(.DATA_WID(DATA_WID), .ADDR_WID(REG_ADDR_WID)) u_rns_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (rns_wr_en_s),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rns_rd_a_s),
        .rd_data_b (rns_rd_b_s)
    );

    // Bank selects travel alongside the registered bank reads so the output mux lines up.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rns_a_r <= 1'b0;
            rd_rns_b_r <= 1'b0;
        end else begin
            rd_rns_a_r <= rd_rns_a;
            rd_rns_b_r <= rd_rns_b;
        end
    end

    assign rd_data_a = rd_rns_a_r ? rns_rd_a_s : DATA_WID'(pack_bin(bin_rd_a_s));
    assign rd_data_b = rd_rns_b_r ? rns_rd_b_s : DATA_WID'(pack_bin(bin_rd_b_s));

    // Scoreboard next state: flush first, then write-back clear, then issue set (newest producer wins).
    always_comb begin
        pend_bin_s = pend_bin_r;
        pend_rns_s = pend_rns_r;
        if (flush) begin
            pend_bin_s = {DEPTH{1'b0}};
            pend_rns_s = {DEPTH{1'b0}};
        end else begin
            pend_bin_s = pend_bin_r;
            pend_rns_s = pend_rns_r;
        end
        if (bin_wr_en_s) begin
            pend_bin_s[wr_addr] = 1'b0;
        end else if (rns_wr_en_s) begin
            pend_rns_s[wr_addr] = 1'b0;
        end else begin
            pend_bin_s = pend_bin_s;
        end
        if (issue_en && (issue_rns == BANK_RNS)) begin
            pend_rns_s[issue_addr] = 1'b1;
        end else if (issue_en) begin
            pend_bin_s[issue_addr] = 1'b1;
        end else begin
            pend_rns_s = pend_rns_s;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_bin_r <= {DEPTH{1'b0}};
            pend_rns_r <= {DEPTH{1'b0}};
        end else begin
            pend_bin_r <= pend_bin_s;
            pend_rns_r <= pend_rns_s;
        end
    end

    // Hazard lookup from current scoreboard state only.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        if (rd_rns_a) begin
            hazard_a = pend_rns_r[rd_addr_a];
        end else begin
            hazard_a = pend_bin_r[rd_addr_a];
        end
        if (rd_rns_b) begin
            hazard_b = pend_rns_r[rd_addr_b];
        end else begin
            hazard_b = pend_bin_r[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_wb_regfile_rns.sv
// Directed self-checking bench for wb_regfile_rns with two RNS domains (16-bit data).
module tb_wb_regfile_rns;

    localparam int ND = 2;
    localparam int AW = 4;
    localparam int DW = ND * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_wr_en;
    logic          destination_RNS;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          rd_rns_a;
    logic          rd_rns_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          issue_rns;
    logic          flush;
    logic          hazard_a;
    logic          hazard_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    wb_regfile_rns #(.NUM_DOMAINS(ND), .REG_ADDR_WID(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_wr_en       (reg_wr_en),
        .destination_RNS (destination_RNS),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_addr_a       (rd_addr_a),
        .rd_addr_b       (rd_addr_b),
        .rd_rns_a        (rd_rns_a),
        .rd_rns_b        (rd_rns_b),
        .rd_data_a       (rd_data_a),
        .rd_data_b       (rd_data_b),
        .issue_en        (issue_en),
        .issue_addr      (issue_addr),
        .issue_rns       (issue_rns),
        .flush           (flush),
        .hazard_a        (hazard_a),
        .hazard_b        (hazard_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_wr_en = 1'b0;
        issue_en  = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic wr(input logic rns, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reg_wr_en       = 1'b1;
        destination_RNS = rns;
        wr_addr         = a;
        wr_data         = d;
    endtask

    task automatic rd(input logic ra, input logic [AW-1:0] aa, input logic rb, input logic [AW-1:0] ab);
        rd_rns_a  = ra;
        rd_addr_a = aa;
        rd_rns_b  = rb;
        rd_addr_b = ab;
    endtask

    task automatic issue(input logic rns, input logic [AW-1:0] a);
        issue_en   = 1'b1;
        issue_rns  = rns;
        issue_addr = a;
    endtask

    initial begin
        reset = 1'b1; reg_wr_en = 1'b0; destination_RNS = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; issue_rns = 1'b0; flush = 1'b0;
        rd(1'b1, 4'd0, 1'b0, 4'd0);
        step(); step();
        idle();
        #1;
        check("reset_rd_a", 32'(rd_data_a), 32'h0);
        check("reset_rd_b", 32'(rd_data_b), 32'h0);
        check("reset_haz_a", 32'(hazard_a), 32'h0);
        check("reset_haz_b", 32'(hazard_b), 32'h0);

        // Basic write/read across banks
        wr(1'b1, 4'd3, 16'hA55A); step();
        wr(1'b0, 4'd3, 16'h007C); step();
        idle(); rd(1'b1, 4'd3, 1'b0, 4'd3); step();
        check("rw_rns_r3", 32'(rd_data_a), 32'hA55A);
        check("rw_bin_r3", 32'(rd_data_b), 32'h007C);

        // Bypass: same bank hits new data, other bank sees stored data
        wr(1'b0, 4'd5, 16'h0011); step();
        wr(1'b1, 4'd5, 16'h1234); rd(1'b1, 4'd5, 1'b0, 4'd5); step();
        idle();
        check("bypass_rns_r5", 32'(rd_data_a), 32'h1234);
        check("bypass_bin_r5", 32'(rd_data_b), 32'h0011);

        // Bank isolation and binary truncation
        wr(1'b0, 4'd3, 16'hFFEE); step();
        idle(); rd(1'b1, 4'd3, 1'b0, 4'd3); step();
        check("iso_rns_r3", 32'(rd_data_a), 32'hA55A);
        check("iso_bin_r3", 32'(rd_data_b), 32'h00EE);

        // Scoreboard set / clear
        issue(1'b1, 4'd7); step();
        idle(); rd(1'b1, 4'd7, 1'b0, 4'd7); #1;
        check("sb_rns_r7_set", 32'(hazard_a), 32'h1);
        check("sb_bin_r7_clr", 32'(hazard_b), 32'h0);
        wr(1'b1, 4'd7, 16'h0707); #1;
        check("sb_no_wb_lookahead", 32'(hazard_a), 32'h1);
        step(); idle(); #1;
        check("sb_rns_r7_wb", 32'(hazard_a), 32'h0);

        // Simultaneous set and clear on the same bit
        issue(1'b1, 4'd2); wr(1'b1, 4'd2, 16'h2222); step();
        idle(); rd(1'b1, 4'd2, 1'b0, 4'd2); #1;
        check("sb_setclr_r2", 32'(hazard_a), 32'h1);
        wr(1'b1, 4'd2, 16'h2223); step(); idle(); #1;
        check("sb_r2_cleared", 32'(hazard_a), 32'h0);

        // Flush with a concurrent issue
        issue(1'b1, 4'd1); step();
        issue(1'b0, 4'd4); step();
        issue(1'b1, 4'd9); step();
        idle(); rd(1'b1, 4'd1, 1'b0, 4'd4); #1;
        check("pre_flush_rns_r1", 32'(hazard_a), 32'h1);
        check("pre_flush_bin_r4", 32'(hazard_b), 32'h1);
        flush = 1'b1; issue(1'b0, 4'd6); step();
        idle(); #1;
        check("flush_rns_r1", 32'(hazard_a), 32'h0);
        check("flush_bin_r4", 32'(hazard_b), 32'h0);
        rd(1'b1, 4'd9, 1'b0, 4'd6); #1;
        check("flush_rns_r9", 32'(hazard_a), 32'h0);
        check("flush_bin_r6", 32'(hazard_b), 32'h1);

        // Reset mid-sequence dominates concurrent write and issue
        wr(1'b1, 4'd11, 16'hBEEF); issue(1'b0, 4'd12); step();
        reset = 1'b1; wr(1'b1, 4'd11, 16'h1111); issue(1'b1, 4'd13);
        rd(1'b1, 4'd11, 1'b1, 4'd3); step();
        idle();
        check("mid_reset_rd_a", 32'(rd_data_a), 32'h0);
        check("mid_reset_rd_b", 32'(rd_data_b), 32'h0);
        rd(1'b1, 4'd13, 1'b0, 4'd12); #1;
        check("mid_reset_haz_r13", 32'(hazard_a), 32'h0);
        check("mid_reset_haz_r12", 32'(hazard_b), 32'h0);
        rd(1'b1, 4'd11, 1'b0, 4'd6); #1;
        check("mid_reset_haz_r6", 32'(hazard_b), 32'h0);
        step();
        check("post_reset_rns_r11", 32'(rd_data_a), 32'h0);
        check("post_reset_bin_r6", 32'(rd_data_b), 32'h0);
        rd(1'b1, 4'd3, 1'b0, 4'd3); step();
        check("post_reset_rns_r3", 32'(rd_data_a), 32'h0);
        check("post_reset_bin_r3", 32'(rd_data_b), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
